// File: rtl/mem_stage_wb_reg_pkg.sv
// Shared constants and helpers for the MEM stage.
// Covers next-PC select encodings, the link register number and branch-taken evaluation.
package mem_stage_wb_reg_pkg;

    localparam logic [1:0] NEXT_PC_PLUS4  = 2'd0;
    localparam logic [1:0] NEXT_PC_BRANCH = 2'd1;
    localparam logic [1:0] NEXT_PC_JUMP   = 2'd2;
    localparam logic [1:0] NEXT_PC_JR     = 2'd3;

    localparam logic [4:0] RA_REG = 5'd31;

    function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/mem_stage_wb_reg_if.sv
// Bundle of EX/MEM inputs and MEM/WB + next-PC outputs for the MEM stage.
// The slave side belongs to the stage; the master side belongs to whoever drives it.
interface mem_stage_wb_reg_if #(parameter int N = 32);

    logic         zero_in;
    logic [N-1:0] alu_result_in;
    logic [N-1:0] data_2_in;
    logic [N-1:0] jump_addr_in;
    logic [N-1:0] branch_addr_in;
    logic [4:0]   write_reg_in;
    logic [N-1:0] pc_4_in;
    logic         jump_in;
    logic         branch_eq_in;
    logic         branch_ne_in;
    logic         mem_read_in;
    logic         mem_write_in;
    logic         mem_to_reg_in;
    logic         reg_write_in;
    logic         jr_in;

    logic [1:0]   next_pc_sel;
    logic [N-1:0] next_pc;
    logic         flush;
    logic         mem_fault;
    logic [N-1:0] read_data_out;
    logic [N-1:0] alu_result_out;
    logic [4:0]   write_reg_out;
    logic [N-1:0] pc_4_out;
    logic         mem_to_reg_out;
    logic         reg_write_out;
    logic         jal_out;

    modport master (
        output zero_in, alu_result_in, data_2_in, jump_addr_in, branch_addr_in,
               write_reg_in, pc_4_in, jump_in, branch_eq_in, branch_ne_in,
               mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, jr_in,
        input  next_pc_sel, next_pc, flush, mem_fault, read_data_out, alu_result_out,
               write_reg_out, pc_4_out, mem_to_reg_out, reg_write_out, jal_out
    );

    modport slave (
        input  zero_in, alu_result_in, data_2_in, jump_addr_in, branch_addr_in,
               write_reg_in, pc_4_in, jump_in, branch_eq_in, branch_ne_in,
               mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, jr_in,
        output next_pc_sel, next_pc, flush, mem_fault, read_data_out, alu_result_out,
               write_reg_out, pc_4_out, mem_to_reg_out, reg_write_out, jal_out
    );

endinterface

// File: rtl/mem_stage_wb_reg_data_memory_ram.sv
// Word-addressed data RAM: synchronous write on posedge, asynchronous read.
// No reset, so contents survive a pipeline reset.
module data_memory_ram #(
    parameter int N         = 32,
    parameter int MEM_DEPTH = 256,
    localparam int AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr_idx,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_idx] <= wdata;
        end
    end

    assign rdata = mem[addr_idx];

endmodule

// File: rtl/mem_stage_wb_reg.sv
// MEM pipeline stage: data memory access, next-PC resolution with flush, and the
// MEM/WB register, which captures on the falling edge so it sees same-cycle RAM writes.
module mem_stage_wb_reg
    import mem_stage_wb_reg_pkg::*;
#(
    parameter int           N         = 32,
    parameter int           MEM_DEPTH = 256,
    parameter logic [N-1:0] DATA_BASE = 'h1001_0000
) (
    input logic             clk,
    input logic             reset,
    mem_stage_wb_reg_if.slave bus
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [N-1:0] offset;
    logic [N-1:0] word_idx;
    logic         access_valid;
    logic         access_req;
    logic         ram_we;
    logic [N-1:0] ram_rdata;
    logic [N-1:0] read_data;
    logic         jal;
    logic         fault_q;

    logic [1:0]   sel;
    logic [N-1:0] target;

    // Addresses below DATA_BASE wrap to a huge index and so fall out of range naturally.
    assign offset       = bus.alu_result_in - DATA_BASE;
    assign word_idx     = offset >> 2;
    assign access_valid = (bus.alu_result_in[1:0] == 2'b00) && (word_idx < N'(MEM_DEPTH));
    assign access_req   = bus.mem_read_in | bus.mem_write_in;

    // Gating with reset drops a store that coincides with reset being asserted.
    assign ram_we = bus.mem_write_in & access_valid & reset;

    data_memory_ram #(
        .N         (N),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .addr_idx (word_idx[AW-1:0]),
        .wdata    (bus.data_2_in),
        .rdata    (ram_rdata)
    );

    assign read_data = (bus.mem_read_in & access_valid) ? ram_rdata : '0;
    assign jal       = bus.jump_in & (bus.write_reg_in == RA_REG);

    always_comb begin
        sel    = NEXT_PC_PLUS4;
        target = bus.pc_4_in;
        if (bus.jr_in) begin
            sel    = NEXT_PC_JR;
            target = bus.alu_result_in;
        end else if (bus.jump_in) begin
            sel    = NEXT_PC_JUMP;
            target = bus.jump_addr_in;
        end else if (branch_taken(bus.branch_eq_in, bus.branch_ne_in, bus.zero_in)) begin
            sel    = NEXT_PC_BRANCH;
            target = bus.branch_addr_in;
        end
    end

    assign bus.next_pc_sel = sel;
    assign bus.next_pc     = target;
    assign bus.flush       = (sel != NEXT_PC_PLUS4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (access_req & ~access_valid) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.mem_fault = fault_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            bus.read_data_out  <= '0;
            bus.alu_result_out <= '0;
            bus.write_reg_out  <= '0;
            bus.pc_4_out       <= '0;
            bus.mem_to_reg_out <= 1'b0;
            bus.reg_write_out  <= 1'b0;
            bus.jal_out        <= 1'b0;
        end else begin
            bus.read_data_out  <= read_data;
            bus.alu_result_out <= bus.alu_result_in;
            bus.write_reg_out  <= bus.write_reg_in;
            bus.pc_4_out       <= bus.pc_4_in;
            bus.mem_to_reg_out <= bus.mem_to_reg_in;
            bus.reg_write_out  <= bus.reg_write_in;
            bus.jal_out        <= jal;
        end
    end

endmodule

// File: tb/tb_mem_stage_wb_reg.sv
// Directed self-checking bench for mem_stage_wb_reg.
// Inputs change just after each negedge; registered outputs are checked just after the next negedge.
module tb_mem_stage_wb_reg;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk;
    logic reset;
    int   check_count;
    int   error_count;

    mem_stage_wb_reg_if #(.N(32)) bus ();

    mem_stage_wb_reg #(
        .N         (32),
        .MEM_DEPTH (256),
        .DATA_BASE (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic idleInputs();
        bus.zero_in        = 1'b0;
        bus.alu_result_in  = '0;
        bus.data_2_in      = '0;
        bus.jump_addr_in   = '0;
        bus.branch_addr_in = '0;
        bus.write_reg_in   = '0;
        bus.pc_4_in        = '0;
        bus.jump_in        = 1'b0;
        bus.branch_eq_in   = 1'b0;
        bus.branch_ne_in   = 1'b0;
        bus.mem_read_in    = 1'b0;
        bus.mem_write_in   = 1'b0;
        bus.mem_to_reg_in  = 1'b0;
        bus.reg_write_in   = 1'b0;
        bus.jr_in          = 1'b0;
    endtask

    task automatic memOp(input logic [31:0] addr, input logic [31:0] wdata, input logic rd, input logic wr);
        idleInputs();
        bus.alu_result_in = addr;
        bus.data_2_in     = wdata;
        bus.mem_read_in   = rd;
        bus.mem_write_in  = wr;
        bus.mem_to_reg_in = rd;
        bus.reg_write_in  = rd;
    endtask

    // One full cycle: posedge (RAM write, fault update) then negedge capture.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;

        // Reset held with every input driven high
        reset = 1'b0;
        bus.zero_in        = 1'b1;
        bus.alu_result_in  = '1;
        bus.data_2_in      = '1;
        bus.jump_addr_in   = '1;
        bus.branch_addr_in = '1;
        bus.write_reg_in   = '1;
        bus.pc_4_in        = '1;
        bus.jump_in        = 1'b1;
        bus.branch_eq_in   = 1'b1;
        bus.branch_ne_in   = 1'b1;
        bus.mem_read_in    = 1'b1;
        bus.mem_write_in   = 1'b1;
        bus.mem_to_reg_in  = 1'b1;
        bus.reg_write_in   = 1'b1;
        bus.jr_in          = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst read_data_out", bus.read_data_out, 32'h0);
        checkOutput("rst alu_result_out", bus.alu_result_out, 32'h0);
        checkOutput("rst write_reg_out", 32'(bus.write_reg_out), 32'h0);
        checkOutput("rst pc_4_out", bus.pc_4_out, 32'h0);
        checkOutput("rst wb ctrl", {29'h0, bus.mem_to_reg_out, bus.reg_write_out, bus.jal_out}, 32'h0);
        checkOutput("rst mem_fault", 32'(bus.mem_fault), 32'h0);
        checkOutput("rst next_pc_sel", 32'(bus.next_pc_sel), 32'd3);
        checkOutput("rst next_pc", bus.next_pc, 32'hFFFF_FFFF);
        checkOutput("rst flush", 32'(bus.flush), 32'h1);

        idleInputs();
        #1;
        reset = 1'b1;
        applyStimulus();

        // Store then load at BASE+8
        memOp(BASE + 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("sw read_data_out", bus.read_data_out, 32'h0);
        checkOutput("sw alu_result_out", bus.alu_result_out, 32'h1001_0008);
        memOp(BASE + 32'h8, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("lw read_data_out", bus.read_data_out, 32'hDEAD_BEEF);
        checkOutput("lw reg_write_out", 32'(bus.reg_write_out), 32'h1);

        // Simultaneous read and write returns the new data
        memOp(BASE + 32'hC, 32'h1234_5678, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("rw read_data_out", bus.read_data_out, 32'h1234_5678);
        memOp(BASE + 32'h8, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("lw8 still", bus.read_data_out, 32'hDEAD_BEEF);

        // Branch resolution
        idleInputs();
        bus.pc_4_in        = 32'h0040_0004;
        bus.branch_addr_in = 32'h0040_0020;
        bus.jump_addr_in   = 32'h0040_0300;
        bus.branch_eq_in   = 1'b1;
        bus.zero_in        = 1'b1;
        #1;
        checkOutput("beq taken sel", 32'(bus.next_pc_sel), 32'd1);
        checkOutput("beq taken pc", bus.next_pc, 32'h0040_0020);
        checkOutput("beq taken flush", 32'(bus.flush), 32'h1);
        bus.zero_in = 1'b0;
        #1;
        checkOutput("beq not sel", 32'(bus.next_pc_sel), 32'd0);
        checkOutput("beq not pc", bus.next_pc, 32'h0040_0004);
        checkOutput("beq not flush", 32'(bus.flush), 32'h0);
        bus.branch_eq_in = 1'b0;
        bus.branch_ne_in = 1'b1;
        #1;
        checkOutput("bne taken sel", 32'(bus.next_pc_sel), 32'd1);
        bus.jump_in = 1'b1;
        #1;
        checkOutput("jump sel", 32'(bus.next_pc_sel), 32'd2);
        checkOutput("jump pc", bus.next_pc, 32'h0040_0300);
        bus.jr_in         = 1'b1;
        bus.alu_result_in = 32'h0040_0100;
        #1;
        checkOutput("jr prio sel", 32'(bus.next_pc_sel), 32'd3);
        checkOutput("jr prio pc", bus.next_pc, 32'h0040_0100);
        checkOutput("jr flush", 32'(bus.flush), 32'h1);

        // Invalid accesses: misaligned and one past the end, both aliasing word 0
        checkOutput("fault before", 32'(bus.mem_fault), 32'h0);
        memOp(BASE, 32'h1111_1111, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("fault after valid sw", 32'(bus.mem_fault), 32'h0);
        memOp(BASE + 32'h2, 32'hBAD0_BAD0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("misaligned fault", 32'(bus.mem_fault), 32'h1);
        memOp(BASE + 32'h400, 32'hBAD1_BAD1, 1'b0, 1'b1);
        applyStimulus();
        memOp(BASE, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("word0 unchanged", bus.read_data_out, 32'h1111_1111);
        memOp(BASE + 32'h2, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("misaligned lw", bus.read_data_out, 32'h0);
        memOp(BASE - 32'h4, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("below base lw", bus.read_data_out, 32'h0);
        memOp(BASE + 32'h3FC, 32'hABCD_0123, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("last word rw", bus.read_data_out, 32'hABCD_0123);
        idleInputs();
        applyStimulus();
        applyStimulus();
        checkOutput("fault sticky", 32'(bus.mem_fault), 32'h1);

        // JAL link capture, then a plain jump with another destination
        idleInputs();
        bus.jump_in      = 1'b1;
        bus.write_reg_in = 5'd31;
        bus.pc_4_in      = 32'h0040_0008;
        bus.reg_write_in = 1'b1;
        applyStimulus();
        checkOutput("jal_out", 32'(bus.jal_out), 32'h1);
        checkOutput("jal pc_4_out", bus.pc_4_out, 32'h0040_0008);
        checkOutput("jal write_reg_out", 32'(bus.write_reg_out), 32'd31);
        bus.write_reg_in = 5'd5;
        applyStimulus();
        checkOutput("j jal_out", 32'(bus.jal_out), 32'h0);

        // Reset mid-operation: pending store dropped, outputs clear at once
        memOp(BASE + 32'h4, 32'h2222_2222, 1'b0, 1'b1);
        applyStimulus();
        memOp(BASE + 32'h4, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("word1 written", bus.read_data_out, 32'h2222_2222);
        memOp(BASE + 32'h4, 32'hCAFE_F00D, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async clr alu_result_out", bus.alu_result_out, 32'h0);
        checkOutput("async clr read_data_out", bus.read_data_out, 32'h0);
        checkOutput("async clr mem_fault", 32'(bus.mem_fault), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        memOp(BASE + 32'h4, 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("dropped store", bus.read_data_out, 32'h2222_2222);
        checkOutput("fault after reset", 32'(bus.mem_fault), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
